i2c_reg_target: RTL and testbench

- Register-bank I2C target (responder) for the existing master, driven from the master's split SDA interface (`scl`, `sda_out`, `sda_out_en`); returns the target's SDA contribution on `sda_in`.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs, and accepts a register pointer.
- Then either writes data bytes into a local register file or transmits register contents back to the master.
- Sits beside the master in the I2C subsystem as a real-bus-compatible replacement for the simple loopback slave.

---
 rtl/i2c_reg_target.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// i2c_reg_target
//   Register-bank I2C target. Oversamples SCL/SDA on clk, detects START/STOP,
//   matches a 7-bit device address, accepts a register pointer, then either
//   writes data bytes into a local register file or returns register contents
//   to the master.
//
//   Optional build macro: I2C_TARGET_AUTOINC_EN
//     defined   - pointer advances (mod NUM_REGS) after every written byte and
//                 every ACKed read byte
//     undefined - pointer stays fixed for the whole frame
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   scl                SCL from the master (sole clock driver)
//   sda_out/_en        master SDA data and drive enable (bus pulled up when _en=0)
//   sda_in             SDA as seen by the master (0 while target pulls low)
//   sda_oe             target is pulling SDA low
//   wr_pulse           one-clk strobe per register written over I2C
//   wr_addr, wr_data   index and data of the last I2C write
//   host_raddr/rdata   combinational local read port (0 when out of range)
//   busy               high from START to STOP
//
// State table
//   IDLE      | bus idle, waiting for START
//   ADDR      | shifting in address + r/w byte
//   ADDR_ACK  | driving ACK for matched address
//   REG       | shifting in register pointer
//   REG_ACK   | driving ACK for valid pointer
//   WDATA     | shifting in a write data byte
//   WDATA_ACK | driving ACK for a written byte
//   RDATA     | shifting out a read data byte
//   RDATA_ACK | sampling master ACK/NACK
//   IGNORE    | not addressed / NACKed, wait for START or STOP

module i2c_reg_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_out,
  input  logic       sda_out_en,
  output logic       sda_in,
  output logic       sda_oe,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] host_raddr,
  output logic [7:0] host_rdata,
  output logic       busy
);

  localparam int         PW    = $clog2(NUM_REGS);
  localparam logic [8:0] NREG9 = 9'(NUM_REGS);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_REG       = 4'd3;
  localparam logic [3:0] ST_REG_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  logic          bus_sda;
  logic          scl_s1, scl_s2, scl_d;
  logic          sda_s1, sda_s2, sda_d;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]    state;
  logic [3:0]    bit_cnt;
  logic [6:0]    shift;
  logic [7:0]    rx_byte;
  logic [PW-1:0] ptr;
  logic          rw;
  logic          acked;
  logic [7:0]    regs [NUM_REGS];

  // Only the master's contribution is synchronised, so the target's own
  // pull-down can never be mistaken for a START/STOP.
  assign bus_sda = sda_out_en ? sda_out : 1'b1;
  assign sda_in  = sda_oe ? 1'b0 : bus_sda;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= bus_sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  // SCL must be high on both sides of the SDA edge so an SDA change that
  // lands in the same sample as an SCL fall is not taken as START/STOP.
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  assign rx_byte = {shift, sda_s2};

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
`ifdef I2C_TARGET_AUTOINC_EN
    if (p == PW'(NUM_REGS - 1))
      return '0;
    else
      return p + PW'(1);
`else
    return p;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= 4'd0;
      shift    <= 7'd0;
      ptr      <= '0;
      rw       <= 1'b0;
      acked    <= 1'b0;
      sda_oe   <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      busy     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VAL;
    end else begin
      wr_pulse <= 1'b0;
      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: sda_oe <= 1'b0;

          ST_ADDR: if (scl_rise) begin
            shift <= rx_byte[6:0];
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              if (rx_byte[7:1] == TARGET_ADDR) begin
                rw    <= rx_byte[0];
                state <= ST_ADDR_ACK;
              end else begin
                state <= ST_IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          // ACK phases: first falling edge (8th) starts the pull-down, the
          // second (9th) releases it and moves on.
          ST_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= ST_REG;
            end
          end

          ST_REG: if (scl_rise) begin
            shift <= rx_byte[6:0];
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              if ({1'b0, rx_byte} < NREG9) begin
                ptr   <= rx_byte[PW-1:0];
                state <= ST_REG_ACK;
              end else begin
                state <= ST_IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          ST_REG_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              bit_cnt <= 4'd0;
              if (rw) begin
                shift  <= regs[ptr][6:0];
                sda_oe <= ~regs[ptr][7];
                state  <= ST_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_WDATA;
              end
            end
          end

          ST_WDATA: if (scl_rise) begin
            shift <= rx_byte[6:0];
            if (bit_cnt == 4'd7) begin
              bit_cnt   <= 4'd0;
              regs[ptr] <= rx_byte;
              wr_pulse  <= 1'b1;
              wr_addr   <= 8'(ptr);
              wr_data   <= rx_byte;
              state     <= ST_WDATA_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          ST_WDATA_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              ptr    <= ptr_next(ptr);
              state  <= ST_WDATA;
            end
          end

          // bit_cnt counts bits already clocked out; the falling edge after
          // the 8th releases SDA for the master's ACK/NACK.
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                acked   <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= ST_RDATA_ACK;
              end else begin
                shift  <= {shift[5:0], 1'b0};
                sda_oe <= ~shift[6];
              end
            end
          end

          // Next byte is only driven on the falling edge, never while SCL
          // is high.
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                state <= ST_IGNORE;
              end else begin
                acked <= 1'b1;
                ptr   <= ptr_next(ptr);
              end
            end else if (scl_fall && acked) begin
              shift   <= regs[ptr][6:0];
              sda_oe  <= ~regs[ptr][7];
              bit_cnt <= 4'd0;
              state   <= ST_RDATA;
            end
          end

          ST_IGNORE: sda_oe <= 1'b0;

          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    host_rdata = 8'h00;
    if ({1'b0, host_raddr} < NREG9)
      host_rdata = regs[host_raddr[PW-1:0]];
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target
//   Directed bench for i2c_reg_target: a bit-banged I2C master drives scl /
//   sda_out / sda_out_en with SCL half-period of 10 clk, and every result is
//   compared against hand-computed values. Expectations for the multi-byte
//   cases follow the I2C_TARGET_AUTOINC_EN macro.

module tb_i2c_reg_target;

  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_out = 1'b1;
  logic       sda_out_en = 1'b0;
  logic       sda_in, sda_oe, wr_pulse, busy;
  logic [7:0] wr_addr, wr_data, host_rdata;
  logic [7:0] host_raddr = 8'h00;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;

  i2c_reg_target dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda_out    (sda_out),
    .sda_out_en (sda_out_en),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    host_raddr = a;
    #1;
    check(tag, host_rdata, exp);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      tick(2);
      sda_out_en = 1'b0;
      tick(H - 2);
      scl = 1'b1;
      tick(H);
    end
    sda_out_en = 1'b1;
    sda_out    = 1'b0;
    tick(H);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(2);
    sda_out_en = 1'b1;
    sda_out    = 1'b0;
    tick(H - 2);
    scl = 1'b1;
    tick(H);
    sda_out_en = 1'b0;
    tick(H);
  endtask

  task automatic send_bit(input logic b);
    tick(2);
    sda_out_en = 1'b1;
    sda_out    = b;
    tick(H - 2);
    scl = 1'b1;
    tick(H);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tick(2);
    sda_out_en = 1'b0;
    tick(H - 2);
    scl = 1'b1;
    tick(H / 2);
    ack = sda_in;
    tick(H - H / 2);
    scl = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d, output logic oe9);
    for (int i = 7; i >= 0; i--) begin
      tick(2);
      sda_out_en = 1'b0;
      tick(H - 2);
      scl = 1'b1;
      tick(H / 2);
      d[i] = sda_in;
      tick(H - H / 2);
      scl = 1'b0;
    end
    tick(2);
    sda_out_en = ~nack;
    sda_out    = 1'b0;
    tick(H - 2);
    scl = 1'b1;
    tick(H / 2);
    oe9 = sda_oe;
    tick(H - H / 2);
    scl = 1'b0;
  endtask

  logic       ack, oe9;
  logic [7:0] rd;
  int         p0;
  logic [7:0] addr_byte;

  initial begin
    // reset state
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_sda_in", sda_in, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_pulse", wr_pulse, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    rd_check("rst_reg5", 8'h05, 8'h00);
    tick(5);

    // write reg 0x05 = 0xA5
    bus_start();
    check("wr_busy_start", busy, 1'b1);
    send_byte(8'hA0, ack);
    check("wr_addr_ack", ack, 1'b0);
    send_byte(8'h05, ack);
    check("wr_reg_ack", ack, 1'b0);
    p0 = pulse_cnt;
    send_byte(8'hA5, ack);
    check("wr_data_ack", ack, 1'b0);
    check("wr_pulse_cnt", pulse_cnt - p0, 1);
    check("wr_addr", wr_addr, 8'h05);
    check("wr_data", wr_data, 8'hA5);
    bus_stop();
    check("wr_busy_stop", busy, 1'b0);
    rd_check("wr_reg5", 8'h05, 8'hA5);
    rd_check("wr_reg4", 8'h04, 8'h00);

    // single-byte read of reg 0x05, master NACK
    bus_start();
    send_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 1'b0);
    send_byte(8'h05, ack);
    check("rd_reg_ack", ack, 1'b0);
    read_byte(1'b1, rd, oe9);
    check("rd_data", rd, 8'hA5);
    check("rd_oe_9th", oe9, 1'b0);
    bus_stop();
    check("rd_busy_stop", busy, 1'b0);

    // two-byte read: ACK then NACK
    bus_start();
    send_byte(8'hA1, ack);
    send_byte(8'h05, ack);
    check("rd2_reg_ack", ack, 1'b0);
    read_byte(1'b0, rd, oe9);
    check("rd2_data0", rd, 8'hA5);
    check("rd2_oe_9th0", oe9, 1'b0);
    read_byte(1'b1, rd, oe9);
`ifdef I2C_TARGET_AUTOINC_EN
    check("rd2_data1", rd, 8'h00);
`else
    check("rd2_data1", rd, 8'hA5);
`endif
    check("rd2_oe_9th1", oe9, 1'b0);
    bus_stop();

    // wrong address 0x51
    p0 = pulse_cnt;
    bus_start();
    send_byte(8'hA2, ack);
    check("bad_addr_nack", ack, 1'b1);
    check("bad_addr_busy", busy, 1'b1);
    send_byte(8'h05, ack);
    check("bad_addr_nack2", ack, 1'b1);
    send_byte(8'h77, ack);
    check("bad_addr_nack3", ack, 1'b1);
    bus_stop();
    check("bad_addr_busy_stop", busy, 1'b0);
    check("bad_addr_pulses", pulse_cnt - p0, 0);
    rd_check("bad_addr_reg5", 8'h05, 8'hA5);

    // out-of-range register index
    p0 = pulse_cnt;
    bus_start();
    send_byte(8'hA0, ack);
    check("bad_reg_addr_ack", ack, 1'b0);
    send_byte(8'h20, ack);
    check("bad_reg_nack", ack, 1'b1);
    send_byte(8'h99, ack);
    check("bad_reg_data_nack", ack, 1'b1);
    bus_stop();
    check("bad_reg_pulses", pulse_cnt - p0, 0);
    rd_check("bad_reg_reg0", 8'h00, 8'h00);
    rd_check("bad_reg_reg5", 8'h05, 8'hA5);
    rd_check("host_out_of_range", 8'h20, 8'h00);

    // reset while target is driving the address ACK
    bus_start();
    addr_byte = 8'hA0;
    for (int i = 7; i >= 0; i--) send_bit(addr_byte[i]);
    tick(2);
    sda_out_en = 1'b0;
    tick(4);
    check("rst_mid_oe_before", sda_oe, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_oe_after", sda_oe, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_wr_addr", wr_addr, 8'h00);
    rd_check("rst_mid_reg5", 8'h05, 8'h00);
    tick(H - 7);
    scl = 1'b1;
    tick(H / 2);
    check("rst_mid_bus_released", sda_in, 1'b1);
    tick(H - H / 2);
    scl = 1'b0;
    bus_stop();

    // full write after the reset
    bus_start();
    send_byte(8'hA0, ack);
    check("post_rst_addr_ack", ack, 1'b0);
    send_byte(8'h03, ack);
    check("post_rst_reg_ack", ack, 1'b0);
    send_byte(8'h3C, ack);
    check("post_rst_data_ack", ack, 1'b0);
    bus_stop();
    rd_check("post_rst_reg3", 8'h03, 8'h3C);
    check("post_rst_wr_addr", wr_addr, 8'h03);

    // two-byte write starting at the last register
    p0 = pulse_cnt;
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h0F, ack);
    check("wrap_reg_ack", ack, 1'b0);
    send_byte(8'h11, ack);
    check("wrap_data0_ack", ack, 1'b0);
    send_byte(8'h22, ack);
    check("wrap_data1_ack", ack, 1'b0);
    bus_stop();
    check("wrap_pulses", pulse_cnt - p0, 2);
    check("wrap_wr_data", wr_data, 8'h22);
`ifdef I2C_TARGET_AUTOINC_EN
    rd_check("wrap_reg15", 8'h0F, 8'h11);
    rd_check("wrap_reg0", 8'h00, 8'h22);
    check("wrap_wr_addr", wr_addr, 8'h00);
`else
    rd_check("wrap_reg15", 8'h0F, 8'h22);
    rd_check("wrap_reg0", 8'h00, 8'h00);
    check("wrap_wr_addr", wr_addr, 8'h0F);
`endif
    rd_check("wrap_reg3", 8'h03, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
